barrel_normalize_32: RTL and testbench
======================================

Name: barrel_normalize_32

Overview:
- Pipelined 32-bit normalizer: the inverse companion of the team's barrel shifter.
- Given a word, it finds the shift amount that a prior shift introduced and removes it:
  - mode 0 counts leading zeros and shifts left until bit 31 is 1;
  - mode 1 counts trailing zeros and shifts right until bit 0 is 1.
- Two-stage pipeline with valid/ready handshakes on both sides.
- Feeds the shift-amount/result pair to downstream datapath blocks (float pack, divider pre-scale).

Parameters:
- WIDTH, 32, data width; must be a power of two, 8..64.
- CNT_W, 6, count width; equals log2(WIDTH)+1 so the value WIDTH (all-zero input) is representable.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept the input this cycle.
- in_mode  input  1  0 = left-normalize (leading zeros), 1 = right-normalize (trailing zeros).
- in_data  input  WIDTH  word to normalize.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_data  output  WIDTH  normalized word.
- out_count  output  CNT_W  shift amount applied (0..WIDTH).
- out_zero  output  1  input word was all zeros.
- out_mode  output  1  mode echoed from the input.

Behaviour:
- Synchronous reset: on a clk edge with rst_n=0, all of the following are cleared to 0:
  - s1_valid, s2_valid, out_valid;
  - out_data, out_count, out_zero, out_mode.
- in_ready is combinational from pipeline state and out_ready; it is not gated by rst_n.
- Transfers: input transfer = in_valid && in_ready; output transfer = out_valid && out_ready.
- Stage 1 (count):
  - on an input transfer, registers in_data, in_mode and cnt;
  - cnt = leading-zero count (mode 0) or trailing-zero count (mode 1);
  - cnt = WIDTH when in_data == 0.
- Stage 2 (shift):
  - out_data = s1_data << cnt (mode 0) or s1_data >> cnt (mode 1), zero fill;
  - out_data = 0 when cnt == WIDTH;
  - out_count = cnt, out_zero = (cnt == WIDTH), out_mode = s1_mode.
- Latency: exactly 2 cycles from an input transfer to out_valid when not stalled. Full throughput: 1 result per cycle while out_ready = 1.
- Flow control:
  - s2 advance = !s2_valid || out_ready.
  - s1 advance into s2 = s1_valid && s2 advance.
  - in_ready = !s1_valid || s1 advance.
- Simultaneous transfers:
  - out transfer and s1 moving into s2 in the same cycle: s2 is reloaded, no bubble.
  - in transfer and s1 moving into s2 in the same cycle: s1 is reloaded.
- Stall: with out_ready = 0, at most 2 words are held (s1 and s2). in_ready drops once both are full. Held outputs stay stable until transferred.
- Ordering: strict FIFO; no drops or duplicates.
- Reset mid-operation: in-flight words are discarded, and out_valid = 0 the cycle after reset.
- Invariants:
  - out_data, out_count and out_zero are stable while out_valid && !out_ready.
  - Mode 0 non-zero result: out_data[WIDTH-1] = 1.
  - Mode 1 non-zero result: out_data[0] = 1.
  - Shifting out_data back by out_count in the opposite direction reproduces the input.

Test Plan:
- Mode 0, in_data 0x0000_0001 -> out_data 0x8000_0000, out_count 31, out_zero 0, out_valid 2 cycles after acceptance.
- Mode 0, in_data 0x8000_0000 -> out_data 0x8000_0000, out_count 0.
- Mode 1, in_data 0x0000_0F00 -> out_data 0x0000_000F, out_count 8.
- Mode 0, same input 0x0000_0F00 -> out_data 0xF000_0000, out_count 20.
- Zero input, either mode, in_data 0 -> out_data 0, out_count 32, out_zero 1.
- Backpressure:
  - Stimulus: out_ready = 0; offer 0x1, 0x2, 0x4 back-to-back in mode 0.
  - While stalled: the first two are accepted, in_ready = 0 on the third offer, out_data holds 0x8000_0000.
  - After raising out_ready: counts 31, 30, 29 appear in order on consecutive cycles, no loss.
- Reset mid-operation:
  - Stimulus: stream in_valid = 1 with random data, out_ready = 1; assert rst_n = 0 for 1 cycle while both stages are full.
  - Required response: out_valid = 0 and out_count = 0 the next cycle. The first word accepted after reset emerges 2 cycles later with the correct count, checked against a reference model across 10k random words and modes.

Source files
------------

// File: rtl/barrel_normalize_32_if.sv
// Handshake bundle for the 32-bit normalizer: input word channel and
// result channel, each with its own valid/ready pair.
interface barrel_normalize_32_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) ();
    // Input channel
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;

    // Result channel
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_zero;
    logic             out_mode;

    // Normalizer side: consumes words, produces results
    modport slave (
        input  in_valid,
        input  in_mode,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_count,
        output out_zero,
        output out_mode,
        input  out_ready
    );

    // Producer/consumer side surrounding the normalizer
    modport master (
        output in_valid,
        output in_mode,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_count,
        input  out_zero,
        input  out_mode,
        output out_ready
    );
endinterface

// File: rtl/barrel_normalize_32.sv
// Two-stage pipelined normalizer. Stage 1 counts leading zeros (mode 0) or
// trailing zeros (mode 1); stage 2 shifts the word by that count so that
// bit WIDTH-1 (mode 0) or bit 0 (mode 1) ends up set. An all-zero word
// reports a count of WIDTH and a zero result.
module barrel_normalize_32 #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                  clk,
    input  logic                  rst_n,
    barrel_normalize_32_if.slave  bus
);

    // Reject unsupported widths at elaboration time
    generate
        if ((WIDTH < 8) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)
            || (CNT_W != $clog2(WIDTH) + 1)) begin : g_bad_param
            $error("barrel_normalize_32: WIDTH must be a power of two in 8..64 and CNT_W = log2(WIDTH)+1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] CNT_ALL_ZERO = CNT_W'(WIDTH);

    // Stage 1 state
    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_data_reg;
    logic             s1_mode_reg;
    logic [CNT_W-1:0] s1_cnt_reg;

    // Stage 2 state (drives the result channel directly)
    logic             s2_valid_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic [CNT_W-1:0] out_count_reg;
    logic             out_zero_reg;
    logic             out_mode_reg;

    // Flow control
    logic s2_advance;
    logic s1_advance;
    logic in_ready_int;
    logic in_fire;

    assign s2_advance   = !s2_valid_reg || bus.out_ready;
    assign s1_advance   = s1_valid_reg && s2_advance;
    assign in_ready_int = !s1_valid_reg || s1_advance;
    assign in_fire      = bus.in_valid && in_ready_int;

    // Leading-zero count is the trailing-zero count of the bit-reversed
    // word, so both modes share one scanner.
    logic [WIDTH-1:0] data_rev;
    logic [WIDTH-1:0] scan_data;
    logic [CNT_W-1:0] cnt_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_rev
            assign data_rev[gi] = bus.in_data[WIDTH-1-gi];
        end
    endgenerate

    assign scan_data = bus.in_mode ? bus.in_data : data_rev;

    // Index of the lowest set bit of scan_data, WIDTH when none is set
    always_comb begin
        cnt_next = CNT_ALL_ZERO;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (scan_data[i]) begin
                cnt_next = CNT_W'(i);
            end
        end
    end

    // Stage 2 shift; a count of WIDTH forces an explicit zero result
    logic [WIDTH-1:0] shift_next;

    always_comb begin
        shift_next = '0;
        if (s1_cnt_reg != CNT_ALL_ZERO) begin
            if (s1_mode_reg) begin
                shift_next = s1_data_reg >> s1_cnt_reg;
            end else begin
                shift_next = s1_data_reg << s1_cnt_reg;
            end
        end
    end

    // Stage 1 occupancy: filled by an input transfer, emptied when it moves on
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
        end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
        end
    end

    // Stage 1 payload; only meaningful while s1_valid_reg is set, so no reset
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_data_reg <= bus.in_data;
            s1_mode_reg <= bus.in_mode;
            s1_cnt_reg  <= cnt_next;
        end
    end

    // Stage 2: reload from stage 1 when it can advance, else drain on output transfer
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid_reg  <= 1'b0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
            out_zero_reg  <= 1'b0;
            out_mode_reg  <= 1'b0;
        end else if (s1_advance) begin
            s2_valid_reg  <= 1'b1;
            out_data_reg  <= shift_next;
            out_count_reg <= s1_cnt_reg;
            out_zero_reg  <= (s1_cnt_reg == CNT_ALL_ZERO);
            out_mode_reg  <= s1_mode_reg;
        end else if (bus.out_ready) begin
            s2_valid_reg  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_count = out_count_reg;
    assign bus.out_zero  = out_zero_reg;
    assign bus.out_mode  = out_mode_reg;

endmodule

// File: tb/tb_barrel_normalize_32.sv
// Self-checking bench for barrel_normalize_32: directed vectors,
// backpressure, reset mid-stream and a long randomized stream checked
// against a behavioural normalizer model with an expected-result queue.
module tb_barrel_normalize_32;

    localparam int WIDTH = 32;
    localparam int CNT_W = 6;

    logic clk;
    logic rst_n;

    barrel_normalize_32_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    barrel_normalize_32 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic [CNT_W-1:0] c;
        logic             z;
        logic             m;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   accepted = 0;
    int   tb_cycles = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Normalize by repeated single-bit shifts until the target bit is set
    function automatic exp_t ref_norm(input logic [WIDTH-1:0] d, input logic m);
        exp_t e;
        e.m = m;
        e.d = d;
        e.c = '0;
        e.z = 1'b0;
        if (d == '0) begin
            e.c = CNT_W'(WIDTH);
            e.z = 1'b1;
        end else if (!m) begin
            while (!e.d[WIDTH-1]) begin
                e.d = e.d << 1;
                e.c = e.c + 1'b1;
            end
        end else begin
            while (!e.d[0]) begin
                e.d = e.d >> 1;
                e.c = e.c + 1'b1;
            end
        end
        return e;
    endfunction

    function automatic logic [WIDTH-1:0] rand_word();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return '0;
        if (r < 5)  return $urandom() >> $urandom_range(0, 31);
        return $urandom() << $urandom_range(0, 31);
    endfunction

    // Compare process: the head of the expected queue must be presented
    // whenever out_valid is high, and is retired on an output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
        end else begin
            if (bus.out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("mon_unexpected_out_valid", 64'(bus.out_valid), 64'd0);
                end else begin
                    e = exp_q[0];
                    chk("mon_data", 64'(bus.out_data), 64'(e.d));
                    chk("mon_count", 64'(bus.out_count), 64'(e.c));
                    chk("mon_zero_mode", 64'({bus.out_zero, bus.out_mode}), 64'({e.z, e.m}));
                    if (bus.out_ready) void'(exp_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_q.push_back(ref_norm(bus.in_data, bus.in_mode));
                accepted++;
            end
        end
    end

    // Hard stop if the bench ever loses its way
    always @(posedge clk) begin
        tb_cycles++;
        if (tb_cycles > 80000) begin
            $display("FAIL watchdog: cycles %0d exceeded limit %0d", tb_cycles, 80000);
            $fatal(1, "watchdog expired");
        end
    end

    // One word through an idle pipe with literal expected results and latency
    task automatic single(input logic [WIDTH-1:0] d, input logic m,
                          input logic [WIDTH-1:0] ed, input logic [CNT_W-1:0] ec,
                          input logic ez);
        @(posedge clk); #1;
        bus.in_valid  = 1'b1;
        bus.in_data   = d;
        bus.in_mode   = m;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("single_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("single_latency_cycle1", 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        chk("single_out_valid", 64'(bus.out_valid), 64'd1);
        chk("single_data", 64'(bus.out_data), 64'(ed));
        chk("single_count", 64'(bus.out_count), 64'(ec));
        chk("single_zero", 64'(bus.out_zero), 64'(ez));
        chk("single_mode", 64'(bus.out_mode), 64'(m));
        $display("single: in=%08h mode=%0d -> data=%08h count=%0d zero=%0d",
                 d, m, bus.out_data, bus.out_count, bus.out_zero);
    endtask

    initial begin
        exp_t fw;
        logic [WIDTH-1:0] fw_d;
        logic fw_m;
        int cyc;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_mode   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("reset_out_data", 64'(bus.out_data), 64'd0);
        chk("reset_out_count", 64'(bus.out_count), 64'd0);
        chk("reset_zero_mode", 64'({bus.out_zero, bus.out_mode}), 64'd0);
        chk("reset_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors
        single(32'h0000_0001, 1'b0, 32'h8000_0000, 6'd31, 1'b0);
        single(32'h8000_0000, 1'b0, 32'h8000_0000, 6'd0,  1'b0);
        single(32'h0000_0F00, 1'b1, 32'h0000_000F, 6'd8,  1'b0);
        single(32'h0000_0F00, 1'b0, 32'hF000_0000, 6'd20, 1'b0);
        single(32'h0000_0000, 1'b0, 32'h0000_0000, 6'd32, 1'b1);
        single(32'h0000_0000, 1'b1, 32'h0000_0000, 6'd32, 1'b1);

        // Backpressure: two words held, third refused, then drained in order
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_mode   = 1'b0;
        bus.in_data   = 32'h1;
        @(negedge clk);
        chk("bp_accept_first", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_data = 32'h2;
        @(negedge clk);
        chk("bp_accept_second", 64'(bus.in_ready), 64'd1);
        @(posedge clk); #1;
        bus.in_data = 32'h4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_refuse_third", 64'(bus.in_ready), 64'd0);
            chk("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            chk("bp_hold_data", 64'(bus.out_data), 64'h8000_0000);
            chk("bp_hold_count", 64'(bus.out_count), 64'd31);
            if (k < 3) @(posedge clk);
        end
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
        chk("bp_drain_count0", 64'(bus.out_count), 64'd31);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain_valid1", 64'(bus.out_valid), 64'd1);
        chk("bp_drain_count1", 64'(bus.out_count), 64'd30);
        @(negedge clk);
        chk("bp_drain_valid2", 64'(bus.out_valid), 64'd1);
        chk("bp_drain_count2", 64'(bus.out_count), 64'd29);
        @(negedge clk);
        chk("bp_drain_empty", 64'(bus.out_valid), 64'd0);
        $display("backpressure: three words drained in order");

        // Reset while both stages hold words
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = rand_word();
        bus.in_mode   = 1'($urandom_range(0, 1));
        repeat (4) begin
            @(posedge clk); #1;
            bus.in_data = rand_word();
            bus.in_mode = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("prereset_out_valid", 64'(bus.out_valid), 64'd1);
        @(posedge clk); #1;
        rst_n       = 1'b0;
        bus.in_data = rand_word();
        @(posedge clk); #1;
        rst_n       = 1'b1;
        fw_d        = rand_word();
        fw_m        = 1'($urandom_range(0, 1));
        bus.in_data = fw_d;
        bus.in_mode = fw_m;
        @(negedge clk);
        chk("midreset_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midreset_out_count", 64'(bus.out_count), 64'd0);
        @(posedge clk); #1;
        bus.in_data = rand_word();
        bus.in_mode = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("postreset_latency_cycle1", 64'(bus.out_valid), 64'd0);
        @(posedge clk); #1;
        bus.in_data = rand_word();
        bus.in_mode = 1'($urandom_range(0, 1));
        @(negedge clk);
        fw = ref_norm(fw_d, fw_m);
        chk("postreset_first_valid", 64'(bus.out_valid), 64'd1);
        chk("postreset_first_data", 64'(bus.out_data), 64'(fw.d));
        chk("postreset_first_count", 64'(bus.out_count), 64'(fw.c));
        $display("reset: first word %08h mode=%0d -> count=%0d", fw_d, fw_m, bus.out_count);

        // Long randomized stream with random stalls on both sides
        accepted = 0;
        cyc      = 0;
        while (accepted < 10000 && cyc < 40000) begin
            @(posedge clk); #1;
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_data   = rand_word();
            bus.in_mode   = 1'($urandom_range(0, 1));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("stream_budget", 64'(accepted >= 10000), 64'd1);
        $display("stream: %0d words accepted in %0d cycles", accepted, cyc);

        // Drain what is still in flight
        @(posedge clk); #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
